// File: rtl/ring_pattern_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ring_pattern_gen_pkg
// Purpose  : Mode encodings and field-width helpers shared by the ring
//            pattern generator and its rotator.
// Revision : 1.0 - initial release
// ============================================================================
package ring_pattern_gen_pkg;

   localparam logic [1:0] MODE_ROL  = 2'b00;
   localparam logic [1:0] MODE_ROR  = 2'b01;
   localparam logic [1:0] MODE_JOHN = 2'b10;
   localparam logic [1:0] MODE_HOLD = 2'b11;

   // Step field must be able to express WIDTH itself (which reduces to 0).
   function automatic int step_width(input int width);
      return $clog2(width) + 1;
   endfunction

   // Period field must hold the longest legal cycle, 2*WIDTH (Johnson).
   function automatic int period_width(input int width);
      return $clog2(2 * width + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ring_rotate.sv
`default_nettype none
// ============================================================================
// Module   : ring_rotate
// Purpose  : Combinational WIDTH-bit barrel rotator, left or right.
//            The amount must already be reduced below WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module ring_rotate
   import ring_pattern_gen_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int SW   = step_width(WIDTH)
) (
   input  logic [WIDTH-1:0] data,
   input  logic [SW-1:0]    amount,
   input  logic             dir_right,
   output logic [WIDTH-1:0] result
);

   localparam logic [SW-1:0] WIDTH_SW = SW'(WIDTH);

   // Complementary shift distance; for amount=0 it equals WIDTH and the
   // wrapped-around term shifts out completely, leaving data unchanged.
   logic [SW-1:0]    back;
   logic [WIDTH-1:0] rol;
   logic [WIDTH-1:0] ror;

   assign back   = WIDTH_SW - amount;
   assign rol    = (data << amount) | (data >> back);
   assign ror    = (data >> amount) | (data << back);
   assign result = dir_right ? ror : rol;

endmodule
`default_nettype wire

// File: rtl/ring_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : ring_pattern_gen
// Purpose  : Ring / Johnson pattern generator with a reference pattern,
//            a one-cycle wrap pulse and a measured cycle period.
// Revision : 1.0 - initial release
// ============================================================================
module ring_pattern_gen
   import ring_pattern_gen_pkg::*;
#(
   parameter int              WIDTH = 8,
   parameter logic [WIDTH-1:0] SEED = WIDTH'(2'b11),
   localparam int             SW    = step_width(WIDTH),
   localparam int             PW    = period_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [1:0]       mode,
   input  logic [SW-1:0]    step,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic [PW-1:0]    period
);

   localparam logic [SW-1:0] WIDTH_SW = SW'(WIDTH);
   localparam logic [PW-1:0] CNT_MAX  = '1;

   logic [WIDTH-1:0] ref_pat;
   logic [PW-1:0]    upd_cnt;
   logic [SW-1:0]    eff_step;
   logic [WIDTH-1:0] rot_out;
   logic [WIDTH-1:0] next_pat;
   logic [PW-1:0]    cnt_inc;
   logic             qualify;

   // A step of WIDTH (or any multiple) is a null rotation.
   assign eff_step = step % WIDTH_SW;

   ring_rotate #(
      .WIDTH     (WIDTH)
   ) u_rotate (
      .data      (count),
      .amount    (eff_step),
      .dir_right (mode == MODE_ROR),
      .result    (rot_out)
   );

   // Only updates that actually move the pattern count toward the period.
   assign qualify = en && (mode != MODE_HOLD) &&
                    ((mode == MODE_JOHN) || (eff_step != '0));

   assign cnt_inc = (upd_cnt == CNT_MAX) ? upd_cnt : upd_cnt + PW'(1);

   // Select the candidate next pattern for the current mode.
   always_comb begin
      next_pat = count;
      case (mode)
         MODE_ROL,
         MODE_ROR:  next_pat = rot_out;
         MODE_JOHN: next_pat = {count[WIDTH-2:0], ~count[WIDTH-1]};
         default:   next_pat = count;
      endcase
   end

   // Pattern, reference, cycle counter, wrap pulse and period registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= SEED;
         ref_pat <= SEED;
         upd_cnt <= '0;
         wrap    <= 1'b0;
         period  <= '0;
      end else if (load) begin
         count   <= load_val;
         ref_pat <= load_val;
         upd_cnt <= '0;
         wrap    <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (qualify) begin
            count <= next_pat;
            if (next_pat == ref_pat) begin
               wrap    <= 1'b1;
               period  <= cnt_inc;
               upd_cnt <= '0;
            end else begin
               upd_cnt <= cnt_inc;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ring_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_pattern_gen
// Purpose  : Self-checking bench for ring_pattern_gen (WIDTH=8, SEED=0x03).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_pattern_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic [1:0] mode = 2'b00;
   logic [3:0] step = 4'd0;
   logic [7:0] count;
   logic       wrap;
   logic [4:0] period;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference model state (plain integers)
   int m_count  = 3;
   int m_ref    = 3;
   int m_upd    = 0;
   int m_wrap   = 0;
   int m_period = 0;

   ring_pattern_gen #(.WIDTH(8), .SEED(8'h03)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .load     (load),
      .load_val (load_val),
      .mode     (mode),
      .step     (step),
      .count    (count),
      .wrap     (wrap),
      .period   (period)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Model: behaviour computed from the rules with integer arithmetic.
   always @(posedge clk or posedge rst) begin
      int s;
      int nxt;
      bit moves;
      if (rst) begin
         m_count = 3; m_ref = 3; m_upd = 0; m_wrap = 0; m_period = 0;
      end else if (load) begin
         m_count = int'(load_val); m_ref = int'(load_val); m_upd = 0; m_wrap = 0;
      end else begin
         m_wrap = 0;
         s      = int'(step) % 8;
         moves  = 1'b0;
         nxt    = m_count;
         if (en && mode == 2'b10) begin
            nxt   = ((m_count * 2) & 255) | ((m_count < 128) ? 1 : 0);
            moves = 1'b1;
         end else if (en && mode == 2'b00 && s != 0) begin
            nxt   = ((m_count << s) | (m_count >> (8 - s))) & 255;
            moves = 1'b1;
         end else if (en && mode == 2'b01 && s != 0) begin
            nxt   = ((m_count >> s) | (m_count << (8 - s))) & 255;
            moves = 1'b1;
         end
         if (moves) begin
            m_count = nxt;
            if (m_upd < 31) m_upd++;
            if (nxt == m_ref) begin
               m_wrap = 1; m_period = m_upd; m_upd = 0;
            end
         end
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      check("count", int'(count), m_count);
      check("wrap", int'(wrap), m_wrap);
      check("period", int'(period), m_period);
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cyc_expect(input string tag, input int c, input int w);
      cyc();
      check({tag, "_count"}, int'(count), c);
      check({tag, "_wrap"}, int'(wrap), w);
   endtask

   initial begin
      int rol_exp[4];
      int ror_exp[8];
      int jv;
      rol_exp = '{8'h0C, 8'h30, 8'hC0, 8'h03};
      ror_exp = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};

      // Reset state
      @(negedge clk);
      check("rst_count", int'(count), 8'h03);
      check("rst_wrap", int'(wrap), 0);
      check("rst_period", int'(period), 0);
      rst = 1'b0;

      // Rotate-left by 2 from seed
      en = 1'b1; mode = 2'b00; step = 4'd2;
      for (int i = 0; i < 4; i++) cyc_expect("rol", rol_exp[i], (i == 3) ? 1 : 0);
      check("rol_period", int'(period), 4);
      en = 1'b0;
      cyc_expect("idle", 8'h03, 0);

      // Load has priority over en: no rotation that cycle
      en = 1'b1; load = 1'b1; load_val = 8'h81;
      cyc_expect("load", 8'h81, 0);
      load = 1'b0;

      // Rotate-right by 1 through a full 8-update cycle
      mode = 2'b01; step = 4'd1;
      for (int i = 0; i < 8; i++) cyc_expect("ror", ror_exp[i], (i == 7) ? 1 : 0);
      check("ror_period", int'(period), 8);

      // Degenerate steps/modes inside one cycle do not disturb the count
      mode = 2'b00; step = 4'd1;
      cyc_expect("mix1", 8'h03, 0);
      cyc_expect("mix2", 8'h06, 0);
      step = 4'd8;
      cyc_expect("step8a", 8'h06, 0);
      cyc_expect("step8b", 8'h06, 0);
      mode = 2'b11; step = 4'd1;
      cyc_expect("hold", 8'h06, 0);
      mode = 2'b01;
      cyc_expect("mix3", 8'h03, 0);
      cyc_expect("mix4", 8'h81, 1);
      check("mix_period", int'(period), 4);

      // Johnson cycle from 0x00 (step ignored)
      en = 1'b0; load = 1'b1; load_val = 8'h00;
      cyc_expect("jload", 8'h00, 0);
      load = 1'b0; en = 1'b1; mode = 2'b10; step = 4'd5;
      for (int k = 1; k <= 16; k++) begin
         jv = (k <= 8) ? ((1 << k) - 1) : ((8'hFF << (k - 8)) & 8'hFF);
         cyc_expect("john", jv, (k == 16) ? 1 : 0);
      end
      check("john_period", int'(period), 16);

      // Reset between edges during a rotate run
      load = 1'b1; load_val = 8'h05;
      cyc();
      load = 1'b0; mode = 2'b00; step = 4'd3;
      cyc();
      cyc();
      #2 rst = 1'b1;
      #1;
      check("mid_rst_count", int'(count), 8'h03);
      check("mid_rst_wrap", int'(wrap), 0);
      check("mid_rst_period", int'(period), 0);
      @(negedge clk);
      rst = 1'b0; step = 4'd2;
      for (int i = 0; i < 4; i++) cyc_expect("rerun", rol_exp[i], (i == 3) ? 1 : 0);
      check("rerun_period", int'(period), 4);
      en = 1'b0;
      cyc();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
